// File: rtl/rob_param.sv
// rob_param: parametrised reorder buffer.
// Entries are allocated at the tail in program order. Execution channels
// write results back out of order. Entries commit from the head one per
// cycle, and a mispredicted branch or a JALR raises a one-cycle flush
// with a redirect pc.
// Ports:
//   clk_in, rst_n_in, rdy_in     clock, async active-low reset, global enable
//   issue_*                      allocation request; issue_tag = current tail
//   rob_full/rob_count/rob_head  registered almost-full, occupancy, head tag
//   wb_valid/wb_tag/wb_value     packed per-channel write-back (channel k at slice k)
//   store_commit_ready           LSB accepts a store commit this cycle
//   commit_*                     registered commit record
//   flush/redirect_pc            registered flush pulse and new fetch pc
module rob_param #(
  parameter int DEPTH       = 32,
  parameter int TAG_W       = 5,
  parameter int WB_PORTS    = 2,
  parameter int FULL_MARGIN = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  issue_valid,
  input  logic [2:0]            issue_kind,
  input  logic [31:0]           issue_pc,
  input  logic [31:0]           issue_imm,
  input  logic [4:0]            issue_rd,
  input  logic                  issue_pred_taken,
  output logic [TAG_W-1:0]      issue_tag,
  output logic                  rob_full,
  output logic [TAG_W:0]        rob_count,
  output logic [TAG_W-1:0]      rob_head,
  input  logic [WB_PORTS-1:0]   wb_valid,
  input  logic [WB_PORTS*TAG_W-1:0] wb_tag,
  input  logic [WB_PORTS*32-1:0] wb_value,
  input  logic                  store_commit_ready,
  output logic                  commit_valid,
  output logic [TAG_W-1:0]      commit_tag,
  output logic [4:0]            commit_rd,
  output logic [31:0]           commit_value,
  output logic                  commit_is_store,
  output logic                  flush,
  output logic [31:0]           redirect_pc
);

  localparam logic [2:0] K_REG    = 3'd0;
  localparam logic [2:0] K_BRANCH = 3'd1;
  localparam logic [2:0] K_JAL    = 3'd2;
  localparam logic [2:0] K_JALR   = 3'd3;
  localparam logic [2:0] K_STORE  = 3'd4;

  localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0] FULL_CNT  = (TAG_W+1)'(DEPTH - FULL_MARGIN);

  // Per-entry state: valid/ready are reset, payload is not.
  logic [DEPTH-1:0] ent_valid, ent_ready, ent_pred;
  logic [2:0]       ent_kind  [DEPTH];
  logic [31:0]      ent_pc    [DEPTH];
  logic [31:0]      ent_imm   [DEPTH];
  logic [31:0]      ent_value [DEPTH];
  logic [4:0]       ent_rd    [DEPTH];

  logic [TAG_W-1:0] head, tail;
  logic [TAG_W:0]   count, count_next;

  logic             issue_fire, commit_fire, mispredict;
  logic [2:0]       kind_norm, h_kind;
  logic [31:0]      h_pc4, h_target, h_value, redirect_next, value_next;
  logic [4:0]       rd_next;

  assign issue_tag = tail;
  assign rob_head  = head;
  assign rob_count = count;

  always_comb begin
    kind_norm   = (issue_kind <= K_STORE) ? issue_kind : K_REG;
    issue_fire  = issue_valid && (count < DEPTH_CNT) && !flush;

    h_kind      = ent_kind[head];
    h_value     = ent_value[head];
    h_pc4       = ent_pc[head] + 32'd4;
    h_target    = ent_pc[head] + ent_imm[head];
    commit_fire = ent_valid[head] && ent_ready[head] && !flush &&
                  ((h_kind != K_STORE) || store_commit_ready);

    mispredict    = 1'b0;
    redirect_next = h_pc4;
    value_next    = h_value;
    rd_next       = 5'd0;
    case (h_kind)
      K_REG:  rd_next = ent_rd[head];
      K_JAL: begin
        // fetch already followed the jump, so only the link value matters
        rd_next    = ent_rd[head];
        value_next = h_pc4;
      end
      K_JALR: begin
        rd_next       = ent_rd[head];
        value_next    = h_pc4;
        mispredict    = 1'b1;
        redirect_next = h_value & ~32'd1;
      end
      K_BRANCH: begin
        mispredict    = (h_value[0] != ent_pred[head]);
        redirect_next = h_value[0] ? h_target : h_pc4;
      end
      default: ;
    endcase

    count_next = count + {{TAG_W{1'b0}}, issue_fire} - {{TAG_W{1'b0}}, commit_fire};
  end

  // Control state. Within a cycle: write-back, then commit clears the head,
  // then issue claims the tail (issue overrides a same-slot write-back).
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      ent_valid       <= '0;
      ent_ready       <= '0;
      rob_full        <= 1'b0;
      commit_valid    <= 1'b0;
      commit_tag      <= '0;
      commit_rd       <= '0;
      commit_value    <= '0;
      commit_is_store <= 1'b0;
      flush           <= 1'b0;
      redirect_pc     <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        head         <= '0;
        tail         <= '0;
        count        <= '0;
        ent_valid    <= '0;
        ent_ready    <= '0;
        rob_full     <= 1'b0;
        commit_valid <= 1'b0;
        flush        <= 1'b0;
      end else begin
        // descending loop: the lowest channel's assignment lands last and wins
        for (int k = WB_PORTS-1; k >= 0; k--)
          if (wb_valid[k] && ent_valid[wb_tag[k*TAG_W +: TAG_W]])
            ent_ready[wb_tag[k*TAG_W +: TAG_W]] <= 1'b1;
        if (commit_fire) begin
          ent_valid[head] <= 1'b0;
          ent_ready[head] <= 1'b0;
          head            <= head + TAG_W'(1);
        end
        if (issue_fire) begin
          ent_valid[tail] <= 1'b1;
          ent_ready[tail] <= (kind_norm == K_STORE);
          tail            <= tail + TAG_W'(1);
        end
        count        <= count_next;
        rob_full     <= (count_next >= FULL_CNT);
        commit_valid <= commit_fire;
        flush        <= commit_fire && mispredict;
        if (commit_fire) begin
          commit_tag      <= head;
          commit_rd       <= rd_next;
          commit_value    <= value_next;
          commit_is_store <= (h_kind == K_STORE);
        end
        if (commit_fire && mispredict)
          redirect_pc <= redirect_next;
      end
    end
  end

  // Payload storage; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !flush) begin
      for (int k = WB_PORTS-1; k >= 0; k--)
        if (wb_valid[k] && ent_valid[wb_tag[k*TAG_W +: TAG_W]])
          ent_value[wb_tag[k*TAG_W +: TAG_W]] <= wb_value[k*32 +: 32];
      if (issue_fire) begin
        ent_kind[tail]  <= kind_norm;
        ent_pc[tail]    <= issue_pc;
        ent_imm[tail]   <= issue_imm;
        ent_rd[tail]    <= issue_rd;
        ent_pred[tail]  <= issue_pred_taken;
        ent_value[tail] <= '0;
      end
    end
  end

endmodule

// File: doc/rob_param.md
Name: rob_param

Overview:
- Parametrised reorder buffer; successor to the fixed 32-entry ROB.
- Sits between issue, the execution write-back channels (ALU, LSB, …) and the register file / fetch redirect.
- Adds:
  - configurable depth and number of write-back channels
  - an exact occupancy counter
  - predicted-taken branch checking, so only mispredicts flush
  - JAL without flush
  - a store-commit handshake with the LSB

Parameters:
- DEPTH, 32, number of entries; power of 2, at least 4.
- TAG_W, 5, log2(DEPTH); width of ROB tags.
- WB_PORTS, 2, number of write-back channels (port 0 = ALU, port 1 = LSB).
- FULL_MARGIN, 4, rob_full asserts when count >= DEPTH-FULL_MARGIN (covers issue pipeline skid).

Ports:
- clk_in  in  1  clock
- rst_n_in  in  1  asynchronous active-low reset
- rdy_in  in  1  global enable; all state holds when low
- issue_valid  in  1  allocate entry at tail
- issue_kind  in  3  0=REG, 1=BRANCH, 2=JAL, 3=JALR, 4=STORE; others treated as REG
- issue_pc  in  32  instruction pc
- issue_imm  in  32  branch/jal offset
- issue_rd  in  5  destination register
- issue_pred_taken  in  1  fetch prediction (branches only)
- issue_tag  out  TAG_W  current tail (combinational)
- rob_full  out  1  registered almost-full
- rob_count  out  TAG_W+1  registered occupancy
- rob_head  out  TAG_W  current head tag
- wb_valid  in  WB_PORTS  per-channel write-back strobe
- wb_tag  in  WB_PORTS*TAG_W  packed tags; channel k at [k*TAG_W +: TAG_W]
- wb_value  in  WB_PORTS*32  packed results; for branches, bit0 = actual taken
- store_commit_ready  in  1  LSB can accept a store commit this cycle
- commit_valid  out  1  registered commit pulse
- commit_tag  out  TAG_W  committed entry
- commit_rd  out  5  destination; 0 for stores/branches
- commit_value  out  32  value written to rd
- commit_is_store  out  1  committed entry was a store
- flush  out  1  registered one-cycle flush pulse
- redirect_pc  out  32  new fetch pc, valid with flush

Behaviour:
- Reset (rst_n_in low, async):
  - head=tail=count=0; all entry ready/valid bits 0.
  - All outputs 0: commit_valid, commit_tag, commit_rd, commit_value, commit_is_store, flush, redirect_pc, rob_full, rob_count.
  - Reset mid-operation discards all entries.
- rdy_in low: no state change; registered outputs hold.
- Issue:
  - Accepted iff issue_valid && count<DEPTH && !flush. Writes the entry at tail; tail <= tail+1 mod DEPTH.
  - STORE entries allocate ready=1; all other kinds allocate ready=0.
  - issue_valid while count==DEPTH is dropped silently; the bench flags it as a protocol error.
- Write-back:
  - For each channel k with wb_valid[k]: if entry wb_tag[k] is valid, set ready=1 and latch the value.
  - Same tag on two channels in one cycle: the lowest k wins.
  - Write-back to an unallocated slot is ignored.
  - An issue to the same slot in the same cycle overrides the write-back.
- Commit:
  - At most one entry per cycle.
  - Head commits when valid && ready && !flush, and, for STORE, store_commit_ready=1.
  - Outputs are registered: visible the cycle after the head becomes committable.
- Commit results by kind:
  - REG: commit_valid=1, commit_rd=rd, commit_value=value.
  - JAL: commit_valid=1, commit_value=pc+4; no flush, since fetch already followed it.
  - JALR: commit_valid=1, commit_value=pc+4; flush=1, redirect_pc = value & ~1.
  - BRANCH: commit_valid=1, commit_rd=0. If value[0] != pred_taken: flush=1; redirect_pc = value[0] ? pc+imm : pc+4.
  - STORE: commit_valid=1, commit_is_store=1, commit_rd=0.
- Counters and flags:
  - count <= count + issue_accepted - commit_fire, exact, wrap-safe.
  - rob_full and rob_count are computed from the next count.
- Flush:
  - Pulse lasts exactly one cycle.
  - In the flush cycle, issue and write-back are ignored and head, tail, count and every valid bit are cleared to 0.
  - The cycle after flush, commit_valid is 0 and the ROB is empty.
- Arithmetic: pc+4 and pc+imm are mod 2^32; tags wrap mod DEPTH.

Test Plan:
- Fill/full: DEPTH=8, FULL_MARGIN=2; issue 8 REG with no write-back -> rob_full rises when count reaches 6; count=8; 9th issue dropped; tail wraps to 0.
- Out-of-order write-back: issue tags 0,1,2; write back 2, then 0 (ch0) and 1 (ch1) in the same cycle -> commits in order 0,1,2 on consecutive cycles with matching rd/values.
- Branch prediction: BRANCH pc=0x100, imm=0x20, pred=1, value=1 -> no flush. Same with value=0 -> flush with redirect_pc=0x104, and count=0 next cycle.
- JAL/JALR: JAL pc=0x200, rd=1 -> commit_value=0x204, flush=0. JALR value=0x301 -> flush, redirect_pc=0x300.
- Store handshake: STORE at head with store_commit_ready=0 for 3 cycles -> no commit. Raise ready -> commit_is_store=1 the next cycle.
- Async reset mid-stream: assert rst_n_in between clock edges with 5 entries live -> all outputs 0 immediately; after release, issue_tag=0.
